// File: rtl/axi_lite_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_master_arbiter
// Description : Shares one AXI4-Lite master port between instruction fetch
//               (port 0) and MEM-stage data access (port 1) using req/done.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_master_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter bit RR_EN      = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [31:0]           m0_wdata,
    input  logic [3:0]            m0_wstrb,
    output logic [31:0]           m0_rdata,
    output logic                  m0_done,
    output logic                  m0_err,

    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [31:0]           m1_wdata,
    input  logic [3:0]            m1_wstrb,
    output logic [31:0]           m1_rdata,
    output logic                  m1_done,
    output logic                  m1_err,

    output logic [ADDR_WIDTH-1:0] awaddr,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [31:0]           wdata,
    output logic [3:0]            wstrb,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready,
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [31:0]           rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_ADDR = 3'd1,
        S_RD_DATA = 3'd2,
        S_WR_REQ  = 3'd3,
        S_WR_RESP = 3'd4
    } state_t;

    state_t                  state_q,   state_d;
    logic                    grant_q,   grant_d;
    logic                    last_q,    last_d;
    logic                    we_q,      we_d;
    logic [ADDR_WIDTH-1:0]   addr_q,    addr_d;
    logic [31:0]             wdata_q,   wdata_d;
    logic [3:0]              wstrb_q,   wstrb_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q,  w_done_d;
    logic                    arvalid_q, arvalid_d;
    logic                    rready_q,  rready_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q,  wvalid_d;
    logic                    bready_q,  bready_d;
    logic [1:0]              done_q,    done_d;
    logic [1:0]              err_q,     err_d;
    logic [31:0]             rdata0_q,  rdata0_d;
    logic [31:0]             rdata1_q,  rdata1_d;

    logic                    w_pick;
    logic                    w_aw_fire;
    logic                    w_w_fire;
    logic                    w_unused;

    // Only resp[1] matters to requesters; bit 0 distinguishes OKAY/EXOKAY.
    assign w_unused = ^{rresp[0], bresp[0]};

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        done_d    = 2'b00;
        err_d     = 2'b00;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        w_pick    = 1'b0;
        w_aw_fire = awvalid_q && awready;
        w_w_fire  = wvalid_q && wready;

        case (state_q)
            S_IDLE: begin
                // A requester still holding req during its done cycle must not be re-granted.
                if ((m0_req || m1_req) && (done_q == 2'b00)) begin
                    if (m0_req && m1_req) begin
                        w_pick = RR_EN ? ~last_q : 1'b1;
                    end else begin
                        w_pick = m1_req;
                    end
                    grant_d   = w_pick;
                    last_d    = w_pick;
                    we_d      = w_pick ? m1_we    : m0_we;
                    addr_d    = w_pick ? m1_addr  : m0_addr;
                    wdata_d   = w_pick ? m1_wdata : m0_wdata;
                    wstrb_d   = w_pick ? m1_wstrb : m0_wstrb;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    if (w_pick ? m1_we : m0_we) begin
                        state_d   = S_WR_REQ;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = S_RD_ADDR;
                        arvalid_d = 1'b1;
                    end
                end
            end

            S_RD_ADDR: begin
                if (arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RD_DATA;
                end
            end

            S_RD_DATA: begin
                if (rvalid && rready_q) begin
                    rready_d        = 1'b0;
                    done_d[grant_q] = 1'b1;
                    err_d[grant_q]  = rresp[1];
                    if (grant_q) begin
                        rdata1_d = rdata;
                    end else begin
                        rdata0_d = rdata;
                    end
                    state_d = S_IDLE;
                end
            end

            S_WR_REQ: begin
                if (w_aw_fire) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_w_fire) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if ((aw_done_q || w_aw_fire) && (w_done_q || w_w_fire)) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    bready_d  = 1'b1;
                    state_d   = S_WR_RESP;
                end
            end

            S_WR_RESP: begin
                if (bvalid && bready_q) begin
                    bready_d        = 1'b0;
                    done_d[grant_q] = 1'b1;
                    err_d[grant_q]  = bresp[1];
                    state_d         = S_IDLE;
                end
            end

            default: begin
                state_d   = S_IDLE;
                arvalid_d = 1'b0;
                rready_d  = 1'b0;
                awvalid_d = 1'b0;
                wvalid_d  = 1'b0;
                bready_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            grant_q   <= 1'b0;
            last_q    <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            done_q    <= 2'b00;
            err_q     <= 2'b00;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            done_q    <= done_d;
            err_q     <= err_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

    assign araddr   = addr_q;
    assign awaddr   = addr_q;
    assign wdata    = wdata_q;
    assign wstrb    = wstrb_q;
    assign arvalid  = arvalid_q;
    assign rready   = rready_q;
    assign awvalid  = awvalid_q;
    assign wvalid   = wvalid_q;
    assign bready   = bready_q;
    assign m0_done  = done_q[0];
    assign m1_done  = done_q[1];
    assign m0_err   = err_q[0];
    assign m1_err   = err_q[1];
    assign m0_rdata = rdata0_q;
    assign m1_rdata = rdata1_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_lite_master_arbiter
// Description : Randomized and directed bench with a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_lite_master_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]  req = 2'b00;
    logic [1:0]  we  = 2'b00;
    logic [31:0] addr  [2];
    logic [31:0] wdat  [2];
    logic [3:0]  wstb  [2];

    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_done, m1_done, m0_err, m1_err;

    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [3:0]  wstrb;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic        awready = 0, wready = 0, bvalid = 0, arready = 0, rvalid = 0;
    logic [1:0]  bresp = 0, rresp = 0;

    axi_lite_master_arbiter #(.ADDR_WIDTH(32), .RR_EN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .m0_req(req[0]), .m0_we(we[0]), .m0_addr(addr[0]), .m0_wdata(wdat[0]), .m0_wstrb(wstb[0]),
        .m0_rdata(m0_rdata), .m0_done(m0_done), .m0_err(m0_err),
        .m1_req(req[1]), .m1_we(we[1]), .m1_addr(addr[1]), .m1_wdata(wdat[1]), .m1_wstrb(wstb[1]),
        .m1_rdata(m1_rdata), .m1_done(m1_done), .m1_err(m1_err),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    // Fixed-priority instance: both ports request forever against an always-ready slave.
    logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_awaddr, fp_araddr, fp_wdata;
    logic [3:0]  fp_wstrb;
    logic        fp_m0_done, fp_m1_done, fp_m0_err, fp_m1_err;
    logic        fp_awvalid, fp_wvalid, fp_bready, fp_arvalid, fp_rready;

    axi_lite_master_arbiter #(.ADDR_WIDTH(32), .RR_EN(1'b0)) dut_fp (
        .clk(clk), .rst(rst),
        .m0_req(1'b1), .m0_we(1'b0), .m0_addr(32'h0000_0100), .m0_wdata(32'h0), .m0_wstrb(4'h0),
        .m0_rdata(fp_m0_rdata), .m0_done(fp_m0_done), .m0_err(fp_m0_err),
        .m1_req(1'b1), .m1_we(1'b0), .m1_addr(32'h0000_0200), .m1_wdata(32'h0), .m1_wstrb(4'h0),
        .m1_rdata(fp_m1_rdata), .m1_done(fp_m1_done), .m1_err(fp_m1_err),
        .awaddr(fp_awaddr), .awvalid(fp_awvalid), .awready(1'b1),
        .wdata(fp_wdata), .wstrb(fp_wstrb), .wvalid(fp_wvalid), .wready(1'b1),
        .bresp(2'b00), .bvalid(fp_bready), .bready(fp_bready),
        .araddr(fp_araddr), .arvalid(fp_arvalid), .arready(1'b1),
        .rdata(32'hCAFE_0000), .rresp(2'b00), .rvalid(fp_rready), .rready(fp_rready)
    );

    int fp_cnt0 = 0, fp_cnt1 = 0;
    always @(negedge clk) begin
        if (fp_m0_done) fp_cnt0 = fp_cnt0 + 1;
        if (fp_m1_done) fp_cnt1 = fp_cnt1 + 1;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Slave data and response are pure functions of the address.
    function automatic logic [31:0] hash(input logic [31:0] a);
        if (a == 32'h0000_1004) return 32'hDEAD_BEEF;
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    // ---------------- AXI slave with per-channel wait counts -----------------
    int ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
    int ar_w = 0, r_w = 0, aw_w = 0, w_w = 0, b_w = 0;
    int ar_hs = 0, aw_hs = 0, w_hs = 0;
    logic [31:0] cap_araddr = 0, cap_awaddr = 0, cap_wdata = 0;
    logic [3:0]  cap_wstrb = 0;
    bit          saw_aw_only = 0;

    always @(negedge clk) begin
        arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
        rdata = 0; rresp = 0; bresp = 0;
        if (rst) begin
            ar_w = 0; r_w = 0; aw_w = 0; w_w = 0; b_w = 0;
        end else begin
            if (arvalid) begin
                if (ar_w >= ar_dly) begin arready = 1; ar_hs++; cap_araddr = araddr; ar_w = 0; end
                else ar_w++;
            end else ar_w = 0;
            if (rready) begin
                if (r_w >= r_dly) begin
                    rvalid = 1; rdata = hash(cap_araddr); rresp = {cap_araddr[4], 1'b0}; r_w = 0;
                end else r_w++;
            end else r_w = 0;
            if (awvalid) begin
                if (aw_w >= aw_dly) begin awready = 1; aw_hs++; cap_awaddr = awaddr; aw_w = 0; end
                else aw_w++;
            end else aw_w = 0;
            if (wvalid) begin
                if (w_w >= w_dly) begin wready = 1; w_hs++; cap_wdata = wdata; cap_wstrb = wstrb; w_w = 0; end
                else w_w++;
            end else w_w = 0;
            if (bready) begin
                if (b_w >= b_dly) begin bvalid = 1; bresp = {cap_awaddr[4], 1'b0}; b_w = 0; end
                else b_w++;
            end else b_w = 0;
            if (awvalid && !wvalid) saw_aw_only = 1;
        end
    end

    // ---------------- reference model -----------------
    bit          last_win = 0;
    logic [31:0] exp_rd [2];
    int          ar0 = 0, aw0 = 0, w0 = 0;

    function automatic logic done_of(input int p);
        return (p == 1) ? m1_done : m0_done;
    endfunction
    function automatic logic err_of(input int p);
        return (p == 1) ? m1_err : m0_err;
    endfunction
    function automatic logic [31:0] rdata_of(input int p);
        return (p == 1) ? m1_rdata : m0_rdata;
    endfunction

    task automatic snapshot();
        ar0 = ar_hs; aw0 = aw_hs; w0 = w_hs;
    endtask

    task automatic model_reset();
        last_win = 0; exp_rd[0] = 0; exp_rd[1] = 0;
        snapshot();
    endtask

    task automatic set_dly(input int a, input int r, input int aw, input int w, input int b);
        ar_dly = a; r_dly = r; aw_dly = aw; w_dly = w; b_dly = b;
    endtask

    task automatic check_completion(input int p);
        int o;
        o = 1 - p;
        if (!we[p]) begin
            chk($sformatf("rdata_p%0d", p), rdata_of(p), hash(addr[p]));
            chk($sformatf("rd_err_p%0d", p), err_of(p), addr[p][4]);
            chk("ar_count", ar_hs - ar0, 1);
            chk("araddr", cap_araddr, addr[p]);
            chk("aw_w_count_on_read", (aw_hs - aw0) + (w_hs - w0), 0);
            exp_rd[p] = hash(addr[p]);
        end else begin
            chk($sformatf("wr_err_p%0d", p), err_of(p), addr[p][4]);
            chk("aw_count", aw_hs - aw0, 1);
            chk("w_count", w_hs - w0, 1);
            chk("ar_count_on_write", ar_hs - ar0, 0);
            chk("awaddr", cap_awaddr, addr[p]);
            chk("wdata", cap_wdata, wdat[p]);
            chk("wstrb", cap_wstrb, wstb[p]);
            chk($sformatf("rdata_hold_p%0d", p), rdata_of(p), exp_rd[p]);
        end
        chk($sformatf("other_rdata_hold_p%0d", o), rdata_of(o), exp_rd[o]);
        chk($sformatf("other_done_err_p%0d", o), {done_of(o), err_of(o)}, 0);
        last_win = p[0];
        snapshot();
    endtask

    // Issue requests on the ports in mask; each drops req on its own done.
    task automatic issue(input logic [1:0] mask);
        logic [1:0] pend;
        int         first, cyc;
        bit         first_seen;
        snapshot();
        if (mask == 2'b11) first = last_win ? 0 : 1;
        else               first = mask[1] ? 1 : 0;
        @(negedge clk);
        req = mask;
        pend = mask; cyc = 0; first_seen = 0;
        while (pend != 0 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            for (int p = 0; p < 2; p++) begin
                if (done_of(p)) begin
                    if (!pend[p]) begin
                        chk($sformatf("unexpected_done_p%0d", p), 1, 0);
                    end else begin
                        if (!first_seen) chk("grant_order", p, first);
                        first_seen = 1;
                        check_completion(p);
                        pend[p] = 0;
                        req[p]  = 0;
                    end
                end
            end
        end
        if (pend != 0) begin
            chk("issue_timeout", pend, 0);
            req = 0;
        end
    endtask

    task automatic wait_done(input int p);
        bit ok;
        ok = 0;
        for (int c = 0; c < 300 && !ok; c++) begin
            @(negedge clk);
            if (done_of(p)) ok = 1;
        end
        if (!ok) chk($sformatf("done_timeout_p%0d", p), 0, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        int   fp0_base, fp1_base, p;
        bit   got;
        addr[0] = 0; addr[1] = 0; wdat[0] = 0; wdat[1] = 0; wstb[0] = 0; wstb[1] = 0;
        exp_rd[0] = 0; exp_rd[1] = 0;
        repeat (3) @(negedge clk);
        rst = 0;
        model_reset();

        // reset state
        chk("reset_ctrl", {arvalid, rready, awvalid, wvalid, bready, m0_done, m1_done, m0_err, m1_err}, 0);
        chk("reset_rdata", {m0_rdata, m1_rdata}, 0);

        // single read on port 1 with two wait cycles on R
        set_dly(0, 2, 0, 0, 0);
        we[1] = 0; addr[1] = 32'h0000_1004;
        issue(2'b10);

        // single write on port 1, W accepted two cycles before AW, SLVERR
        saw_aw_only = 0;
        set_dly(0, 0, 2, 0, 0);
        we[1] = 1; addr[1] = 32'h0000_0010; wdat[1] = 32'h1234_5678; wstb[1] = 4'h3;
        issue(2'b10);
        chk("w_handshake_before_aw", saw_aw_only, 1);

        // back-to-back on port 0, req held through the done cycle
        set_dly(0, 0, 0, 0, 0);
        we[0] = 0; addr[0] = 32'h0;
        snapshot();
        @(negedge clk); req[0] = 1;
        wait_done(0);
        check_completion(0);
        @(negedge clk); addr[0] = 32'h4;
        wait_done(0);
        check_completion(0);
        req[0] = 0;

        // contention from reset, round-robin
        set_dly(1, 0, 0, 0, 1);
        @(negedge clk);
        rst = 1; req = 2'b11; we = 2'b00; addr[0] = 32'h0000_0100; addr[1] = 32'h0000_0204;
        @(negedge clk);
        rst = 0;
        model_reset();
        fp0_base = fp_cnt0; fp1_base = fp_cnt1;
        for (int k = 0; k < 4; k++) begin
            got = 0; p = 0;
            for (int c = 0; c < 300 && !got; c++) begin
                @(negedge clk);
                if (m0_done || m1_done) begin got = 1; p = m1_done ? 1 : 0; end
            end
            if (!got) chk("contention_timeout", 0, 1);
            else begin
                chk($sformatf("rr_grant_%0d", k), p, (k % 2 == 0) ? 1 : 0);
                check_completion(p);
            end
        end
        req = 2'b00;
        chk("fp_m0_never_done", fp_cnt0 - fp0_base, 0);
        chk("fp_m1_served", (fp_cnt1 - fp1_base) >= 2, 1);

        // reset while waiting for R data
        repeat (3) @(negedge clk);
        set_dly(0, 20, 0, 0, 0);
        we[0] = 0; addr[0] = 32'h0000_0040;
        @(negedge clk); req[0] = 1;
        for (int c = 0; c < 50 && !rready; c++) @(negedge clk);
        chk("reached_rd_data", rready, 1);
        req = 0; rst = 1;
        @(negedge clk);
        rst = 0;
        model_reset();
        chk("abort_ctrl", {arvalid, rready, awvalid, wvalid, bready, m0_done, m1_done, m0_err, m1_err}, 0);
        chk("abort_rdata", {m0_rdata, m1_rdata}, 0);
        acc = 0;
        repeat (5) begin @(negedge clk); acc = acc | m0_done | m1_done; end
        chk("abort_no_done", acc, 0);
        set_dly(0, 1, 0, 0, 0);
        issue(2'b01);

        // zero-wait read latency
        set_dly(0, 0, 0, 0, 0);
        we[0] = 0; addr[0] = 32'h0000_0008;
        snapshot();
        @(posedge clk); #1 req[0] = 1;
        @(posedge clk); #1 chk("lat_e1_arvalid", {arvalid, m0_done}, 2'b10);
        @(posedge clk); #1 chk("lat_e2_rready", {rready, m0_done}, 2'b10);
        @(posedge clk); #1 chk("lat_e3_done", m0_done, 1);
        check_completion(0);
        req[0] = 0;
        @(negedge clk);

        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            for (int q = 0; q < 2; q++) begin
                we[q]   = 1'($urandom_range(0, 1));
                addr[q] = $urandom & 32'h0000_0FFC;
                wdat[q] = $urandom;
                wstb[q] = 4'($urandom_range(0, 15));
            end
            set_dly($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3));
            issue(2'($urandom_range(1, 3)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
